mrfm_sweep_ctrl: RTL and testbench
==================================

// Module: mrfm_sweep_ctrl
// PURPOSE
//  Frequency-sweep sequencer for the MRFM receive/transmit loop. Steps the shared phase-accumulator
//  frequency register (FR_MRFM_FREQ) through a programmed list, waits a settle time and then a dwell
//  time per step, counted in decimated output strobes. It also arbitrates the serial settings bus
//  between host writes and its own writes. Sits between the host serial interface and the MRFM
//  processing chain; its serial_* outputs feed every setting_reg/phase_acc in the chain.
// PARAMETERS
//  FREQ_ADDR   `FR_MRFM_FREQ        serial address written for each new step frequency
//  BASE_ADDR   `FR_MRFM_SWEEP_BASE  first of 4 sweep config addresses: +0 START, +1 STEP, +2 CFG, +3 CTRL
// PORTS
//  clock          in   1   system clock
//  reset          in   1   synchronous, active-low reset
//  enable         in   1   chain enable; low forces IDLE, same as abort
//  host_addr      in   7   host serial address
//  host_data      in   32  host serial data
//  host_strobe    in   1   host serial write strobe
//  strobe_in      in   1   decimated-rate strobe from the chain (the CIC output strobe)
//  serial_addr    out  7   arbitrated serial address to the chain
//  serial_data    out  32  arbitrated serial data
//  serial_strobe  out  1   arbitrated write strobe
//  busy           out  1   sweep active (not IDLE)
//  dwell_valid    out  1   strobe_in qualified: high on strobe_in cycles in DWELL
//  step_index     out  16  current step number
//  step_done      out  1   1-cycle pulse at end of each step's dwell
//  sweep_done     out  1   1-cycle pulse when the final step completes (non-loop mode)
// BEHAVIOUR
//  - Reset (reset==0 at a clock edge): every output 0, FSM=IDLE, all counters and config registers 0.
//  - Config registers: START[31:0]; STEP[31:0] (two's complement); CFG = {dwell[31:16], nsteps[15:0]};
//    CTRL = {settle[31:16], -, loop[2], abort[1], go[0]}. go and abort are write pulses and are not stored.
//  - Config is latched into working registers on an accepted go. Writes made while busy take effect
//    at the next go. nsteps==0 is treated as 1; dwell==0 is treated as 1.
//  - Arbitration: all serial outputs are registered, so host pass-through latency is 1 cycle.
//    The host has absolute priority. A sweep write is issued only on a cycle with host_strobe==0;
//    otherwise it stays pending. At most one write is issued per cycle.
//  - Host writes to FREQ_ADDR pass through; the sweep overwrites that value at its next step.
//  - FSM:
//    IDLE   : accepted go (enable=1, abort=0) -> freq=START, step_index=0, go to WRITE.
//    WRITE  : issue {FREQ_ADDR,freq} when the bus is free. If settle==0 go to DWELL, else SETTLE.
//    SETTLE : count strobe_in; after settle strobes go to DWELL.
//    DWELL  : dwell_valid=strobe_in; count strobe_in. After dwell strobes, pulse step_done.
//             If step_index==nsteps-1: loop=1 -> freq=START, step_index=0, go to WRITE;
//             loop=0 -> pulse sweep_done, go to IDLE.
//             Otherwise freq+=STEP (mod 2^32, wraps silently), step_index++, go to WRITE.
//  - abort write or enable==0: IDLE on the next edge, from any state. Any pending sweep write is
//    dropped. No step_done or sweep_done pulse. The last written frequency stays in the chain.
//  - go and abort in the same write (both bits set): abort wins. go while busy: ignored.
//  - A strobe_in arriving in the same cycle as a state change is counted by the new state only
//    if that state is SETTLE or DWELL and was entered on an earlier edge, so no strobe counts twice.
// STRUCTURE
//  - Register address macros go in mrfm.vh: FR_MRFM_SWEEP_BASE (and +0..+3), beside FR_MRFM_FREQ/DECIM.
//  - FSM state encodings are localparams in this file.
//  - Reuse setting_reg for START, STEP and CFG. CTRL is decoded in place because of its pulse bits.
//  - One sub-module: mrfm_bus_arb (2-requester, fixed-priority, registered serial mux with pending flag).
// TESTING
//  - START=0x1000_0000, STEP=0x0100_0000, nsteps=3, dwell=4, settle=0, go -> FREQ writes
//    0x10000000/0x11000000/0x12000000, each followed by exactly 4 dwell_valid, 3 step_done, 1 sweep_done.
//  - Hold host_strobe high 3 cycles when a sweep write is due -> 3 host writes emerge 1 cycle late, then
//    the sweep write; no write lost or duplicated.
//  - START=0xFFFF_FF00, STEP=0x200, nsteps=2 -> second written freq is 0x0000_0100 (wrap).
//  - Mid-DWELL abort -> busy=0 next cycle, no further FREQ writes, no step_done/sweep_done.
//  - loop=1, nsteps=2 -> freq sequence A,A+S,A,A+S...; then reset=0 mid-SETTLE -> all outputs 0 next edge.
//  - settle=5, dwell=0 -> 5 strobes ignored, then exactly 1 dwell_valid per step; go+abort in same write -> stays IDLE.

Source files
------------

// File: rtl/mrfm_sweep_ctrl_pkg.sv
// Shared definitions for the MRFM frequency-sweep sequencer: serial register
// map, FSM state type, config word layout and a small clamping helper.
package mrfm_sweep_ctrl_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 32;

  // Serial settings-bus register map for the MRFM chain.
  localparam logic [ADDR_W-1:0] FR_MRFM_FREQ        = 7'd16;
  localparam logic [ADDR_W-1:0] FR_MRFM_DECIM       = 7'd17;
  localparam logic [ADDR_W-1:0] FR_MRFM_SWEEP_BASE  = 7'd20;
  localparam logic [ADDR_W-1:0] FR_MRFM_SWEEP_START = FR_MRFM_SWEEP_BASE + 7'd0;
  localparam logic [ADDR_W-1:0] FR_MRFM_SWEEP_STEP  = FR_MRFM_SWEEP_BASE + 7'd1;
  localparam logic [ADDR_W-1:0] FR_MRFM_SWEEP_CFG   = FR_MRFM_SWEEP_BASE + 7'd2;
  localparam logic [ADDR_W-1:0] FR_MRFM_SWEEP_CTRL  = FR_MRFM_SWEEP_BASE + 7'd3;

  // CTRL word bit positions; go and abort are write pulses, never stored.
  localparam int unsigned CTRL_GO_BIT    = 0;
  localparam int unsigned CTRL_ABORT_BIT = 1;
  localparam int unsigned CTRL_LOOP_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DWELL  = 2'd3
  } sweep_state_t;

  // CFG word: dwell length in strobes (upper half), number of steps (lower half).
  typedef struct packed {
    logic [15:0] dwell;
    logic [15:0] nsteps;
  } cfg_word_t;

  // A programmed count of zero behaves as one.
  function automatic logic [15:0] at_least_one(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/mrfm_bus_arb.sv
// Two-requester serial settings-bus arbiter. The host has absolute priority;
// the sweep request is parked in a single pending slot and issued on the first
// cycle the host leaves the bus free. All serial outputs are registered.
module mrfm_bus_arb
  import mrfm_sweep_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_strobe,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              flush,
  output logic              grant,
  output logic [ADDR_W-1:0] serial_addr,
  output logic [DATA_W-1:0] serial_data,
  output logic              serial_strobe
);

  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  // The pending write goes out only when the host is idle and nobody is
  // cancelling the sweep in this same cycle.
  assign grant = pend & ~host_strobe & ~flush;

  // Pending slot: loaded by the sweep, cleared when issued or flushed.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments for every register so all flops update
    // together at the edge regardless of statement order.
    if (!reset) begin
      pend      <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else if (flush) begin
      pend <= 1'b0;
    end else if (load) begin
      pend      <= 1'b1;
      pend_addr <= load_addr;
      pend_data <= load_data;
    end else if (grant) begin
      pend <= 1'b0;
    end
  end

  // Registered serial mux: host first, then the granted sweep write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      serial_strobe <= 1'b0;
      serial_addr   <= '0;
      serial_data   <= '0;
    end else begin
      serial_strobe <= host_strobe | grant;
      if (host_strobe) begin
        serial_addr <= host_addr;
        serial_data <= host_data;
      end else if (grant) begin
        serial_addr <= pend_addr;
        serial_data <= pend_data;
      end
    end
  end

endmodule

// File: rtl/mrfm_sweep_ctrl.sv
// MRFM frequency-sweep sequencer. Steps the chain frequency register through
// START, START+STEP, ... for nsteps steps, waiting settle then dwell decimated
// strobes per step, and shares the serial settings bus with the host.
module mrfm_sweep_ctrl
  import mrfm_sweep_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FREQ_ADDR = FR_MRFM_FREQ,
  parameter logic [ADDR_W-1:0] BASE_ADDR = FR_MRFM_SWEEP_BASE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_strobe,
  input  logic              strobe_in,
  output logic [ADDR_W-1:0] serial_addr,
  output logic [DATA_W-1:0] serial_data,
  output logic              serial_strobe,
  output logic              busy,
  output logic              dwell_valid,
  output logic [15:0]       step_index,
  output logic              step_done,
  output logic              sweep_done
);

  // Host-visible config registers.
  logic [DATA_W-1:0] cfg_start;
  logic [DATA_W-1:0] cfg_step;
  cfg_word_t         cfg_word;

  // Working copies latched on an accepted go.
  logic [DATA_W-1:0] w_start;
  logic [DATA_W-1:0] w_step;
  logic [15:0]       w_nsteps;
  logic [15:0]       w_dwell;
  logic [15:0]       w_settle;
  logic              w_loop;

  sweep_state_t      state;
  logic [DATA_W-1:0] freq;
  logic [15:0]       cnt;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic              grant;

  // Host register decode.
  logic hit_start, hit_step, hit_cfg, hit_ctrl;
  logic go_req, abort_req, kill;
  logic [15:0] ctrl_settle;
  logic        ctrl_loop;

  assign hit_start   = host_strobe && (host_addr == BASE_ADDR);
  assign hit_step    = host_strobe && (host_addr == BASE_ADDR + 7'd1);
  assign hit_cfg     = host_strobe && (host_addr == BASE_ADDR + 7'd2);
  assign hit_ctrl    = host_strobe && (host_addr == BASE_ADDR + 7'd3);
  assign ctrl_settle = host_data[31:16];
  assign ctrl_loop   = host_data[CTRL_LOOP_BIT];
  // Abort wins over go when both bits arrive in the same write.
  assign abort_req   = hit_ctrl & host_data[CTRL_ABORT_BIT];
  assign go_req      = hit_ctrl & host_data[CTRL_GO_BIT] & ~host_data[CTRL_ABORT_BIT];
  assign kill        = abort_req | ~enable;

  // START/STEP/CFG setting registers; writes while busy apply at the next go.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cfg_start <= '0;
      cfg_step  <= '0;
      cfg_word  <= '0;
    end else begin
      if (hit_start) cfg_start <= host_data;
      if (hit_step)  cfg_step  <= host_data;
      if (hit_cfg)   cfg_word  <= cfg_word_t'(host_data);
    end
  end

  // Sweep FSM with registered status outputs and single-cycle pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_IDLE;
      w_start     <= '0;
      w_step      <= '0;
      w_nsteps    <= '0;
      w_dwell     <= '0;
      w_settle    <= '0;
      w_loop      <= 1'b0;
      freq        <= '0;
      cnt         <= '0;
      load        <= 1'b0;
      load_data   <= '0;
      busy        <= 1'b0;
      dwell_valid <= 1'b0;
      step_index  <= '0;
      step_done   <= 1'b0;
      sweep_done  <= 1'b0;
    end else begin
      load        <= 1'b0;
      dwell_valid <= 1'b0;
      step_done   <= 1'b0;
      sweep_done  <= 1'b0;
      if (kill) begin
        // Abort or chain disable: drop everything, no completion pulses.
        state <= ST_IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (go_req) begin
              w_start    <= cfg_start;
              w_step     <= cfg_step;
              w_nsteps   <= at_least_one(cfg_word.nsteps);
              w_dwell    <= at_least_one(cfg_word.dwell);
              w_settle   <= ctrl_settle;
              w_loop     <= ctrl_loop;
              freq       <= cfg_start;
              step_index <= '0;
              cnt        <= '0;
              load       <= 1'b1;
              load_data  <= cfg_start;
              busy       <= 1'b1;
              state      <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            if (grant) begin
              cnt   <= '0;
              state <= (w_settle == 16'd0) ? ST_DWELL : ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (strobe_in) begin
              if (cnt == w_settle - 16'd1) begin
                cnt   <= '0;
                state <= ST_DWELL;
              end else begin
                cnt <= cnt + 16'd1;
              end
            end
          end
          ST_DWELL: begin
            if (strobe_in) begin
              dwell_valid <= 1'b1;
              if (cnt == w_dwell - 16'd1) begin
                cnt       <= '0;
                step_done <= 1'b1;
                if (step_index == w_nsteps - 16'd1) begin
                  if (w_loop) begin
                    freq       <= w_start;
                    step_index <= '0;
                    load       <= 1'b1;
                    load_data  <= w_start;
                    state      <= ST_WRITE;
                  end else begin
                    sweep_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                  end
                end else begin
                  freq       <= freq + w_step;
                  step_index <= step_index + 16'd1;
                  load       <= 1'b1;
                  load_data  <= freq + w_step;
                  state      <= ST_WRITE;
                end
              end else begin
                cnt <= cnt + 16'd1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  mrfm_bus_arb u_arb (
    .clock         (clock),
    .reset         (reset),
    .host_addr     (host_addr),
    .host_data     (host_data),
    .host_strobe   (host_strobe),
    .load          (load),
    .load_addr     (FREQ_ADDR),
    .load_data     (load_data),
    .flush         (kill),
    .grant         (grant),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe)
  );

endmodule

// File: tb/tb_mrfm_sweep_ctrl.sv
// Directed bench for mrfm_sweep_ctrl: basic sweep, host priority, wrap,
// abort, loop with reset, settle/zero-dwell, go+abort and enable handling.
module tb_mrfm_sweep_ctrl;
  import mrfm_sweep_ctrl_pkg::*;

  localparam logic [6:0] A_FREQ  = FR_MRFM_FREQ;
  localparam logic [6:0] A_START = FR_MRFM_SWEEP_BASE;
  localparam logic [6:0] A_STEP  = FR_MRFM_SWEEP_BASE + 7'd1;
  localparam logic [6:0] A_CFG   = FR_MRFM_SWEEP_BASE + 7'd2;
  localparam logic [6:0] A_CTRL  = FR_MRFM_SWEEP_BASE + 7'd3;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [6:0]  host_addr;
  logic [31:0] host_data;
  logic        host_strobe;
  logic        strobe_in;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic        serial_strobe;
  logic        busy;
  logic        dwell_valid;
  logic [15:0] step_index;
  logic        step_done;
  logic        sweep_done;

  int vectors = 0;
  int miscompares = 0;

  mrfm_sweep_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .host_addr     (host_addr),
    .host_data     (host_data),
    .host_strobe   (host_strobe),
    .strobe_in     (strobe_in),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe),
    .busy          (busy),
    .dwell_valid   (dwell_valid),
    .step_index    (step_index),
    .step_done     (step_done),
    .sweep_done    (sweep_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Decimated strobe source: one pulse every strobe_period cycles when enabled.
  bit strobe_en = 1'b0;
  int strobe_period = 2;
  int strobe_phase = 0;
  always @(posedge clock) begin
    #1;
    if (strobe_en) begin
      strobe_in = (strobe_phase == 0);
      strobe_phase = (strobe_phase + 1 >= strobe_period) ? 0 : strobe_phase + 1;
    end else begin
      strobe_in = 1'b0;
      strobe_phase = 0;
    end
  end

  // Output monitor, sampled on the falling edge.
  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } wr_t;
  wr_t         wr_log[$];
  logic [31:0] freq_log[$];
  int          dv_per[$];
  int          dv_total, sd_total, swd_total;
  int          cyc = 0;

  always @(negedge clock) begin
    cyc++;
    if (serial_strobe === 1'b1) begin
      wr_log.push_back({serial_addr, serial_data, 32'(cyc)});
      if (serial_addr == A_FREQ) begin
        freq_log.push_back(serial_data);
        dv_per.push_back(0);
      end
    end
    if (dwell_valid === 1'b1) begin
      dv_total++;
      if (dv_per.size() > 0) dv_per[dv_per.size()-1]++;
    end
    if (step_done === 1'b1) sd_total++;
    if (sweep_done === 1'b1) swd_total++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    freq_log.delete();
    dv_per.delete();
    dv_total = 0;
    sd_total = 0;
    swd_total = 0;
  endtask

  task automatic host_write(input logic [6:0] a, input logic [31:0] d);
    host_addr = a;
    host_data = d;
    host_strobe = 1'b1;
    tick();
    host_strobe = 1'b0;
  endtask

  task automatic configure(input logic [31:0] start, input logic [31:0] step,
                           input logic [15:0] dwell, input logic [15:0] nsteps);
    host_write(A_START, start);
    host_write(A_STEP, step);
    host_write(A_CFG, {dwell, nsteps});
  endtask

  task automatic go_write(input logic [15:0] settle, input logic loop);
    host_write(A_CTRL, {settle, 13'd0, loop, 1'b0, 1'b1});
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", name, busy, budget);
    end
  endtask

  task automatic check_freqs(input string name, input logic [31:0] exp_f[$]);
    vectors++;
    if (freq_log.size() != exp_f.size()) begin
      miscompares++;
      $display("FAIL %s_freq_count: got %0d, want %0d", name, freq_log.size(), exp_f.size());
    end
    foreach (exp_f[i]) begin
      logic [31:0] got;
      got = (i < freq_log.size()) ? freq_log[i] : 32'hxxxx_xxxx;
      vectors++;
      if (got !== exp_f[i]) begin
        miscompares++;
        $display("FAIL %s_freq[%0d]: got %h, want %h", name, i, got, exp_f[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b1;
    host_strobe = 1'b0;
    host_addr = '0;
    host_data = '0;
    tick(3);
    vectors++;
    if ({serial_strobe, serial_addr, serial_data} !== 40'd0) begin
      miscompares++;
      $display("FAIL reset_serial: got %b/%h/%h, want 0/00/00000000", serial_strobe, serial_addr, serial_data);
    end
    vectors++;
    if ({busy, dwell_valid, step_index, step_done, sweep_done} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_status: got busy=%b dv=%b idx=%0d sd=%b swd=%b, want all 0",
               busy, dwell_valid, step_index, step_done, sweep_done);
    end
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_basic_sweep();
    clear_logs();
    configure(32'h1000_0000, 32'h0100_0000, 16'd4, 16'd3);
    strobe_period = 3;
    strobe_en = 1'b1;
    go_write(16'd0, 1'b0);
    wait_idle(400, "basic");
    tick(2);
    check_freqs("basic", '{32'h1000_0000, 32'h1100_0000, 32'h1200_0000});
    for (int i = 0; i < 3; i++) begin
      int got;
      got = (i < dv_per.size()) ? dv_per[i] : -1;
      vectors++;
      if (got != 4) begin
        miscompares++;
        $display("FAIL basic_dwell_valid[%0d]: got %0d, want 4", i, got);
      end
    end
    vectors++;
    if (sd_total != 3 || swd_total != 1) begin
      miscompares++;
      $display("FAIL basic_pulses: got step_done=%0d sweep_done=%0d, want 3/1", sd_total, swd_total);
    end
    vectors++;
    if (step_index !== 16'd2) begin
      miscompares++;
      $display("FAIL basic_step_index: got %0d, want 2", step_index);
    end
  endtask

  task automatic test_host_priority();
    logic [6:0]  exp_a[4] = '{7'd100, 7'd101, 7'd102, A_FREQ};
    logic [31:0] exp_d[4] = '{32'h1111, 32'h2222, 32'h3333, 32'hABCD_0000};
    strobe_en = 1'b0;
    clear_logs();
    configure(32'hABCD_0000, 32'd1, 16'd1, 16'd1);
    go_write(16'd0, 1'b0);
    host_write(7'd100, 32'h1111);
    host_write(7'd101, 32'h2222);
    host_write(7'd102, 32'h3333);
    tick(4);
    vectors++;
    if (wr_log.size() != 8) begin
      miscompares++;
      $display("FAIL prio_write_count: got %0d, want 8", wr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (wr_log[i+4].addr !== exp_a[i] || wr_log[i+4].data !== exp_d[i]) begin
          miscompares++;
          $display("FAIL prio_order[%0d]: got %h:%h, want %h:%h", i,
                   wr_log[i+4].addr, wr_log[i+4].data, exp_a[i], exp_d[i]);
        end
        vectors++;
        if (wr_log[i+4].cyc !== wr_log[3].cyc + 32'(i + 1)) begin
          miscompares++;
          $display("FAIL prio_timing[%0d]: got cycle %0d, want %0d", i,
                   wr_log[i+4].cyc, wr_log[3].cyc + 32'(i + 1));
        end
      end
    end
    vectors++;
    if (freq_log.size() != 1) begin
      miscompares++;
      $display("FAIL prio_freq_dup: got %0d freq writes, want 1", freq_log.size());
    end
    host_write(A_CTRL, 32'h2);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_abort_busy: got %b, want 0", busy);
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    configure(32'hFFFF_FF00, 32'h0000_0200, 16'd1, 16'd2);
    strobe_period = 2;
    strobe_en = 1'b1;
    go_write(16'd0, 1'b0);
    wait_idle(200, "wrap");
    tick(2);
    check_freqs("wrap", '{32'hFFFF_FF00, 32'h0000_0100});
    vectors++;
    if (swd_total != 1) begin
      miscompares++;
      $display("FAIL wrap_sweep_done: got %0d, want 1", swd_total);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    int nf;
    clear_logs();
    configure(32'h2000_0000, 32'h0000_0010, 16'd8, 16'd4);
    strobe_period = 2;
    strobe_en = 1'b1;
    go_write(16'd0, 1'b0);
    while (dv_total < 2 && n < 100) begin
      tick();
      n++;
    end
    vectors++;
    if (dv_total < 2) begin
      miscompares++;
      $display("FAIL abort_reach_dwell: got %0d dwell_valid, want >=2", dv_total);
    end
    host_write(A_CTRL, 32'h0000_0002);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_busy: got %b, want 0", busy);
    end
    nf = freq_log.size();
    tick(40);
    vectors++;
    if (freq_log.size() != nf || freq_log.size() != 1) begin
      miscompares++;
      $display("FAIL abort_freq_writes: got %0d, want 1", freq_log.size());
    end
    vectors++;
    if (sd_total != 0 || swd_total != 0) begin
      miscompares++;
      $display("FAIL abort_pulses: got step_done=%0d sweep_done=%0d, want 0/0", sd_total, swd_total);
    end
  endtask

  task automatic test_loop_reset();
    int n = 0;
    clear_logs();
    configure(32'h0300_0000, 32'h0001_0000, 16'd2, 16'd2);
    strobe_period = 2;
    strobe_en = 1'b1;
    go_write(16'd3, 1'b1);
    while (freq_log.size() < 5 && n < 400) begin
      @(negedge clock);
      n++;
    end
    check_freqs("loop", '{32'h0300_0000, 32'h0301_0000, 32'h0300_0000, 32'h0301_0000, 32'h0300_0000});
    vectors++;
    if (sd_total != 4 || swd_total != 0) begin
      miscompares++;
      $display("FAIL loop_pulses: got step_done=%0d sweep_done=%0d, want 4/0", sd_total, swd_total);
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
    vectors++;
    if ({serial_strobe, serial_addr, serial_data, busy, dwell_valid, step_index, step_done, sweep_done} !== 60'd0) begin
      miscompares++;
      $display("FAIL loop_reset_outputs: got ss=%b sa=%h sd=%h busy=%b dv=%b idx=%0d sdn=%b swd=%b, want all 0",
               serial_strobe, serial_addr, serial_data, busy, dwell_valid, step_index, step_done, sweep_done);
    end
    reset = 1'b1;
    strobe_en = 1'b0;
    tick(2);
  endtask

  task automatic test_settle_dwell0();
    clear_logs();
    configure(32'h0500_0000, 32'h0000_0100, 16'd0, 16'd2);
    strobe_period = 2;
    strobe_en = 1'b1;
    go_write(16'd5, 1'b0);
    wait_idle(300, "settle");
    tick(2);
    check_freqs("settle", '{32'h0500_0000, 32'h0500_0100});
    vectors++;
    if (dv_per.size() != 2 || dv_per[0] != 1 || dv_per[1] != 1) begin
      miscompares++;
      $display("FAIL settle_dwell_valid: got total %0d over %0d steps, want 1 per step", dv_total, dv_per.size());
    end
    vectors++;
    if (sd_total != 2 || swd_total != 1) begin
      miscompares++;
      $display("FAIL settle_pulses: got step_done=%0d sweep_done=%0d, want 2/1", sd_total, swd_total);
    end
  endtask

  task automatic test_go_abort_same();
    clear_logs();
    host_write(A_CTRL, 32'h0000_0003);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL goabort_busy: got %b, want 0", busy);
    end
    tick(10);
    vectors++;
    if (busy !== 1'b0 || freq_log.size() != 0) begin
      miscompares++;
      $display("FAIL goabort_idle: got busy=%b freq writes=%0d, want 0/0", busy, freq_log.size());
    end
  endtask

  task automatic test_enable_low();
    clear_logs();
    strobe_en = 1'b0;
    configure(32'h0700_0000, 32'h10, 16'd2, 16'd3);
    go_write(16'd0, 1'b0);
    tick(4);
    go_write(16'd0, 1'b0);
    tick(4);
    vectors++;
    if (busy !== 1'b1 || freq_log.size() != 1 || step_index !== 16'd0) begin
      miscompares++;
      $display("FAIL busy_go_ignored: got busy=%b freq writes=%0d idx=%0d, want 1/1/0",
               busy, freq_log.size(), step_index);
    end
    enable = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_low_busy: got %b, want 0", busy);
    end
    enable = 1'b1;
    strobe_en = 1'b1;
    tick(10);
    vectors++;
    if (busy !== 1'b0 || freq_log.size() != 1 || sd_total != 0) begin
      miscompares++;
      $display("FAIL enable_low_stays_idle: got busy=%b freq writes=%0d step_done=%0d, want 0/1/0",
               busy, freq_log.size(), sd_total);
    end
    strobe_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b1;
    host_strobe = 1'b0;
    host_addr = '0;
    host_data = '0;
    strobe_in = 1'b0;
    test_reset();
    test_basic_sweep();
    test_host_priority();
    test_wrap();
    test_abort();
    test_loop_reset();
    test_settle_dwell0();
    test_go_abort_same();
    test_enable_low();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
